// File: rtl/pool1_maxpool_if.sv
// pool1_maxpool_if: start/done handshake, OMEM read port and PMEM write port of the pool1 stage.
interface pool1_maxpool_if #(
  parameter int CH = 8,
  parameter int DW = 8
);
  logic start;
  logic done;
  logic in_en;
  logic [9:0] in_addr;
  logic [CH*DW-1:0] in_dout;
  logic out_en;
  logic [7:0] out_addr;
  logic [CH*DW-1:0] out_din;
  modport master (input start, in_dout, output done, in_en, in_addr, out_en, out_addr, out_din);
  modport slave (output start, in_dout, input done, in_en, in_addr, out_en, out_addr, out_din);
endinterface

// File: rtl/pool1_maxpool.sv
// pool1_maxpool: 2x2 stride-2 max-pool of an IN_DIM x IN_DIM x CH map, four OMEM reads per pooled PMEM word.
module pool1_maxpool #(
  parameter int IN_DIM = 26,
  parameter int CH = 8,
  parameter int DW = 8,
  parameter int SIGNED = 1,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic resetn,
  pool1_maxpool_if.master bus
);
  localparam int W = CH * DW;
  localparam int OD = IN_DIM / 2;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] k;
  logic [3:0] pc, pr;
  logic [9:0] base;
  logic [7:0] wr_idx;
  logic [RD_LAT-1:0] vld;
  logic [1:0] ktag [RD_LAT];
  logic [W-1:0] acc, mx;
  logic go, last_col, last_row, last_rd, last_wr;
  function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++)
      r[i*DW +: DW] = ((SIGNED != 0) ? ($signed(a[i*DW +: DW]) > $signed(b[i*DW +: DW]))
                                     : (a[i*DW +: DW] > b[i*DW +: DW])) ? a[i*DW +: DW] : b[i*DW +: DW];
    return r;
  endfunction
  assign go = state == IDLE && bus.start;
  assign last_col = pc == 4'(OD - 1);
  assign last_row = pr == 4'(OD - 1);
  assign last_rd = bus.in_en && k == 2'd3 && last_col && last_row;
  assign last_wr = bus.out_en && bus.out_addr == 8'(OD * OD - 1);
  assign mx = vmax(acc, bus.in_dout);
  assign bus.in_en = state == READ;
  assign bus.done = state == DONE;
  // window offsets 0, 1, IN_DIM, IN_DIM+1 selected by k
  assign bus.in_addr = base + (k[1] ? 10'(IN_DIM) : 10'd0) + {9'd0, k[0]};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? READ : IDLE;
      READ: state_nx = last_rd ? DRAIN : READ;
      DRAIN: state_nx = last_wr ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      k <= '0;
      pc <= '0;
      pr <= '0;
      base <= '0;
      wr_idx <= '0;
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) ktag[i] <= '0;
      acc <= '0;
      bus.out_en <= 1'b0;
      bus.out_addr <= '0;
      bus.out_din <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        k <= '0;
        pc <= '0;
        pr <= '0;
        base <= '0;
        wr_idx <= '0;
        bus.out_addr <= '0;
      end else if (bus.in_en) begin
        k <= k + 2'd1;
        if (k == 2'd3) begin
          pc <= last_col ? '0 : pc + 4'd1;
          pr <= last_col ? (last_row ? '0 : pr + 4'd1) : pr;
          base <= last_rd ? '0 : base + (last_col ? 10'(IN_DIM + 2) : 10'd2);
        end
      end
      // valid/k tags travel alongside the read for RD_LAT cycles
      vld[0] <= bus.in_en;
      ktag[0] <= k;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        ktag[i] <= ktag[i-1];
      end
      bus.out_en <= 1'b0;
      if (vld[RD_LAT-1]) begin
        acc <= ktag[RD_LAT-1] == 2'd0 ? bus.in_dout : mx;
        if (ktag[RD_LAT-1] == 2'd3) begin
          bus.out_din <= mx;
          bus.out_en <= 1'b1;
          bus.out_addr <= wr_idx;
          wr_idx <= wr_idx + 8'd1;
        end
      end
    end
endmodule

// File: tb/tb_pool1_maxpool.sv
// tb_pool1_maxpool: directed runs over four pool1 instances (RD_LAT 1/2/3 signed, RD_LAT 1 unsigned)
// sharing clock, reset and start, each with its own latency-matched OMEM model and write monitor.
module tb_pool1_maxpool;
  localparam int N = 4;
  localparam int D = 26;
  logic clk = 0, resetn = 1, start = 0, clr = 0;
  int cyc = 0, t0 = 0, pat = 0, checks = 0, errors = 0;
  int wcnt_a [N], bad_a [N], first_a [N], dcyc_a [N], dcnt_a [N];
  logic [63:0] w0_a [N], w168_a [N], odin_a [N];
  logic [2:0] ctl_a [N];
  logic [9:0] iaddr_a [N];
  logic [7:0] oaddr_a [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem(input int a);
    int r, c, o;
    logic [63:0] w;
    r = a / D;
    c = a % D;
    o = (r % 2) * 2 + c % 2;
    w = '0;
    if (pat == 0) w = {8{8'(a >> 3)}};
    else if (pat == 1) w[7:0] = (o == 0) ? 8'h80 : 8'h7f;
    else for (int i = 0; i < 8; i++) w[8*i +: 8] = (o == i % 4) ? 8'(16 + i) : 8'h01;
    return w;
  endfunction

  function automatic logic [63:0] expect_word(input int p, input bit sg);
    logic [63:0] w;
    w = '0;
    if (pat == 0) w = {8{8'((((p / 13) * 2 + 1) * D + (p % 13) * 2 + 1) >> 3)}};
    else if (pat == 1) w[7:0] = sg ? 8'h7f : 8'h80;
    else w = 64'h1716151413121110;
    return w;
  endfunction

  function automatic int lat(input int i);
    return i == 1 ? 2 : i == 2 ? 3 : 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int L = (g == 1) ? 2 : (g == 2) ? 3 : 1;
    localparam int S = (g == 3) ? 0 : 1;
    pool1_maxpool_if #(.CH(8), .DW(8)) bus ();
    logic [63:0] q [L];
    int wcnt, bad, first, dcyc, dcnt;
    logic [63:0] w0, w168;
    pool1_maxpool #(.IN_DIM(D), .CH(8), .DW(8), .SIGNED(S), .RD_LAT(L)) dut (
      .clk(clk), .resetn(resetn), .bus(bus));
    assign bus.start = start;
    assign bus.in_dout = q[L-1];
    always @(posedge clk) begin
      q[0] <= mem(int'(bus.in_addr));
      for (int i = 1; i < L; i++) q[i] <= q[i-1];
    end
    always @(negedge clk)
      if (clr) begin
        wcnt <= 0; bad <= 0; first <= 0; dcyc <= 0; dcnt <= 0; w0 <= '0; w168 <= '0;
      end else begin
        if (bus.out_en === 1'b1) begin
          if (wcnt == 0) begin
            first <= cyc - t0;
            w0 <= bus.out_din;
          end
          if (wcnt == 168) w168 <= bus.out_din;
          if (bus.out_addr !== 8'(wcnt) || bus.out_din !== expect_word(wcnt, S == 1)) bad <= bad + 1;
          wcnt <= wcnt + 1;
        end
        if (bus.done === 1'b1) begin
          dcnt <= dcnt + 1;
          dcyc <= cyc - t0;
        end
      end
    assign wcnt_a[g] = wcnt;
    assign bad_a[g] = bad;
    assign first_a[g] = first;
    assign dcyc_a[g] = dcyc;
    assign dcnt_a[g] = dcnt;
    assign w0_a[g] = w0;
    assign w168_a[g] = w168;
    assign ctl_a[g] = {bus.in_en, bus.out_en, bus.done};
    assign iaddr_a[g] = bus.in_addr;
    assign oaddr_a[g] = bus.out_addr;
    assign odin_a[g] = bus.out_din;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (dcnt_a[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic kick();
    @(posedge clk);
    #1 t0 = cyc;
    start = 1;
    clr = 1;
    @(posedge clk);
    #1 start = 0;
    clr = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!all_done() && n < 1000) begin
      @(negedge clk);
      #1 n++;
    end
    chk("done_seen", 64'(all_done()), 64'd1);
  endtask

  task automatic check_run(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_writes"}, 64'(wcnt_a[i]), 64'd169);
      chk({tag, "_data"}, 64'(bad_a[i]), 64'd0);
      chk({tag, "_done_pulses"}, 64'(dcnt_a[i]), 64'd1);
      chk({tag, "_first_cycle"}, 64'(first_a[i]), 64'(5 + lat(i)));
      chk({tag, "_done_cycle"}, 64'(dcyc_a[i]), 64'(678 + lat(i)));
    end
  endtask

  initial begin
    #2 resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_ctl", 64'(ctl_a[i]), 64'd0);
      chk("rst_in_addr", 64'(iaddr_a[i]), 64'd0);
      chk("rst_out_addr", 64'(oaddr_a[i]), 64'd0);
      chk("rst_out_din", odin_a[i], 64'd0);
    end
    resetn = 1;
    pat = 0;
    kick();
    wait_done();
    check_run("ramp");
    for (int i = 0; i < N; i++) begin
      chk("ramp_word0", w0_a[i], {8{8'd3}});
      chk("ramp_word168", w168_a[i], {8{8'd84}});
    end
    kick();
    wait_done();
    check_run("b2b");
    for (int i = 0; i < N; i++) begin
      chk("b2b_word0", w0_a[i], {8{8'd3}});
      chk("b2b_word168", w168_a[i], {8{8'd84}});
    end
    pat = 1;
    kick();
    wait_done();
    check_run("sign");
    for (int i = 0; i < N; i++)
      chk("sign_word0", w0_a[i], (i == 3) ? 64'h80 : 64'h7f);
    pat = 2;
    kick();
    wait_done();
    check_run("lanes");
    for (int i = 0; i < N; i++) chk("lanes_word168", w168_a[i], 64'h1716151413121110);
    pat = 0;
    kick();
    repeat (299) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done();
    check_run("midstart");
    kick();
    repeat (199) @(posedge clk);
    #1 resetn = 0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("abort_ctl", 64'(ctl_a[i]), 64'd0);
      chk("abort_out_addr", 64'(oaddr_a[i]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("abort_writes", 64'(wcnt_a[i]), (i == 2) ? 64'd48 : 64'd49);
      chk("abort_no_done", 64'(dcnt_a[i]), 64'd0);
      chk("abort_idle", 64'(ctl_a[i]), 64'd0);
    end
    kick();
    wait_done();
    check_run("restart");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
